// File: rtl/dsp_out_collector.sv
// dsp_out_collector: tracks ops issued into a fixed-latency DSP pipe and buffers their results in a FWFT FIFO.
module dsp_out_collector #(
  parameter int REGWIDTH = 48,
  parameter int LATENCY  = 4,
  parameter int DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      s_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REGWIDTH-1:0]       pipe_data,
  output logic [REGWIDTH-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [REGWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [AW:0]         credits;
  logic [LATENCY-1:0]  tracker;
  logic                accept, pop, wr_en, full, wr;
  assign in_ready  = credits < (AW+1)'(DEPTH);
  assign accept    = in_valid & in_ready;
  assign out_valid = count != '0;
  assign pop       = out_valid & out_ready;
  assign wr_en     = tracker[LATENCY-1];
  assign full      = count == (AW+1)'(DEPTH);
  // a write into a full FIFO is only allowed when the head leaves in the same cycle
  assign wr        = wr_en & (~full | pop);
  assign out_data  = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (s_rst) begin
      tracker  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      credits  <= '0;
      overflow <= 1'b0;
    end else begin
      tracker  <= LATENCY'({tracker, accept});
      rd_ptr   <= rd_ptr + AW'(pop);
      wr_ptr   <= wr_ptr + AW'(wr);
      count    <= count + (AW+1)'(wr) - (AW+1)'(pop);
      credits  <= credits + (AW+1)'(accept) - (AW+1)'(pop);
      overflow <= overflow | (wr_en & full & ~pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!s_rst && wr) mem[wr_ptr] <= pipe_data;
  end
endmodule

// File: tb/tb_dsp_out_collector.sv
// tb_dsp_out_collector: directed checks of reset, latency/order, credits, full-boundary writes, overflow and mid-flight reset.
module tb_dsp_out_collector;
  logic        clk = 1'b0;
  logic        s_rst, in_valid, in_ready, out_valid, out_ready, overflow;
  logic [47:0] pipe_data, out_data;
  logic [3:0]  count;
  int          total = 0, passed = 0, failed = 0, acc = 0;
  logic [47:0] drain_exp [8];

  dsp_out_collector dut (
    .clk(clk), .s_rst(s_rst), .in_valid(in_valid), .in_ready(in_ready),
    .pipe_data(pipe_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue one op, idle three edges, then present its result on the capture cycle
  task automatic issue(input logic [47:0] data, input logic pop_at_capture, input logic forced);
    if (forced) force dut.credits = '0;
    in_valid = 1'b1;
    step();
    if (forced) release dut.credits;
    in_valid  = 1'b0;
    pipe_data = 48'hDEAD;
    repeat (3) step();
    pipe_data = data;
    out_ready = pop_at_capture;
    step();
    out_ready = 1'b0;
    pipe_data = '0;
  endtask

  initial begin
    s_rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; pipe_data = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_overflow", overflow, 0);
    end
    // accepts at the first three edges after reset falls
    s_rst = 1'b0;
    repeat (3) step();
    in_valid = 1'b0;
    step();
    chk("lat_no_early", out_valid, 0);
    for (int i = 1; i <= 3; i++) begin
      pipe_data = 48'(i);
      step();
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, 48'(i));
      chk("lat_count", count, 1);
    end
    step();
    chk("lat_drained", out_valid, 0);

    // backpressure: in_valid held, consumer stalled
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pipe_data = 48'h10 + 48'(i);
      if (in_ready) acc++;
      step();
      if (i == 7) chk("bp_count_mid", count, 4);
    end
    chk("bp_accepts", acc, 8);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_count_full", count, 8);
    chk("bp_overflow", overflow, 0);
    chk("bp_head", out_data, 48'h14);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_in_ready", in_ready, 1);
    chk("pop_count", count, 7);
    chk("pop_head", out_data, 48'h15);

    issue(48'hA1, 1'b0, 1'b0);
    chk("refill_count", count, 8);
    chk("refill_head", out_data, 48'h15);

    // write and pop together while full
    issue(48'hA2, 1'b1, 1'b1);
    chk("full_wp_count", count, 8);
    chk("full_wp_overflow", overflow, 0);
    chk("full_wp_head", out_data, 48'h16);

    // write while full without a pop
    issue(48'hA3, 1'b0, 1'b1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_head", out_data, 48'h16);

    drain_exp = '{48'h16, 48'h17, 48'h18, 48'h19, 48'h1A, 48'h1B, 48'hA1, 48'hA2};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", out_data, drain_exp[i]);
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);
    chk("drain_count", count, 0);
    chk("ovf_sticky", overflow, 1);

    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    chk("ovf_cleared", overflow, 0);
    chk("rst_credits", dut.credits, 0);

    // mid-flight reset: two buffered, three in flight
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) pipe_data = 48'hB0;
      if (i == 5) begin pipe_data = 48'hB1; in_valid = 1'b0; end
      step();
    end
    chk("mid_count", count, 2);
    chk("mid_head", out_data, 48'hB0);
    chk("mid_in_ready", in_ready, 1);
    s_rst = 1'b1; pipe_data = 48'hBB;
    step();
    s_rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_credits", dut.credits, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_late", {out_valid, count}, 0);
    end

    issue(48'hC1, 1'b0, 1'b0);
    chk("post_valid", out_valid, 1);
    chk("post_data", out_data, 48'hC1);
    chk("post_count", count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dsp_out_collector.md
Name: dsp_out_collector

Overview:
Downstream (reader) end of the DSP unit's fixed-latency, register-enabled datapath. The block tracks every operation issued into the pipeline and captures the matching result word when it emerges. It buffers results in a small FIFO and presents them on a valid/ready output port. Credit-based issue control guarantees that no in-flight result can find the buffer full.

Parameters:
REGWIDTH, 48, width of result word and out_data
LATENCY, 4, edges from issue acceptance to result capture (>=1)
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all logic on rising edge
s_rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream issues an operation into the DSP pipeline this cycle
in_ready  output  1  issue permitted; accept = in_valid & in_ready
pipe_data  input  REGWIDTH  DSP pipeline result word
out_data  output  REGWIDTH  head-of-FIFO result
out_valid  output  1  out_data holds a result
out_ready  input  1  consumer takes out_data when out_valid high
count  output  $clog2(DEPTH)+1  FIFO occupancy
overflow  output  1  sticky error flag

Behaviour:
- Reset: clk and s_rst only, synchronous, active-high.
  - s_rst high at an edge clears tracker, rd/wr pointers, count, credits and overflow.
  - After reset: out_valid=0, count=0, overflow=0, in_ready=1. FIFO memory contents are don't-care.
  - Reset mid-operation discards all in-flight operations and buffered results; no capture occurs at the reset edge.
- Tracker:
  - LATENCY-bit shift register. tracker[0] <= accept; tracker[i] <= tracker[i-1].
  - wr_en = tracker[LATENCY-1].
  - When wr_en is high, pipe_data is sampled into mem[wr_ptr] at the next edge.
- Timing contract: accept at edge k means pipe_data must be valid during the cycle before edge k+LATENCY. out_valid can first rise after edge k+LATENCY.
- Credits:
  - Register credits = count + in-flight operations, range 0..DEPTH.
  - +1 on accept, -1 on pop, unchanged when both happen in the same cycle.
  - in_ready = (credits < DEPTH), combinational from the credits register.
  - in_valid while in_ready=0 is ignored: not tracked, no credit taken.
- FIFO:
  - pop = out_valid & out_ready.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], combinational read, first-word fall-through.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count +1 on write only, -1 on pop only, unchanged on simultaneous write+pop.
- Boundary conditions:
  - Empty with wr_en high: no pop that cycle. out_valid rises after the edge and out_data = captured word.
  - Full (count=DEPTH) with wr_en and pop together: both performed, count stays DEPTH.
  - Full with wr_en and no pop: write suppressed, overflow set to 1 and held until s_rst. Unreachable under the credit contract; defensive only.
  - out_ready high while out_valid low: no effect.
- Ordering: strict issue order, no reordering.

Test Plan:
- Reset behaviour: assert s_rst for 2 cycles with in_valid=1 and out_ready=1 -> out_valid=0, count=0, in_ready=1, overflow=0 throughout. First accept occurs at the first edge after s_rst falls.
- Latency and order (LATENCY=4):
  - Stimulus: accept 3 ops at edges 10,11,12; drive pipe_data=48'h1,2,3 in the cycles before edges 14,15,16; out_ready=1.
  - Required: out_valid high after edges 14..16, out_data 1,2,3 in order, count never exceeds 1.
- Backpressure and credits (DEPTH=8):
  - Stimulus: out_ready=0, in_valid held 1.
  - Required: exactly 8 accepts, then in_ready=0. count reaches 8 after 4 more edges with no overflow.
  - Release out_ready for one pop -> in_ready returns 1 the next cycle.
- Simultaneous write+pop at full:
  - Stimulus: count=8, one op in flight after a pop, out_ready=1 on the capture cycle.
  - Required: count stays 8 and data order is preserved across the pointer wrap (wr_ptr 7->0).
- Overflow flag: force tracker capture while full, by driving in_valid past the contract via a bench override -> overflow=1 and stays 1 until s_rst. The FIFO contents are unaltered.
- Reset mid-flight: 3 ops in flight and 2 buffered, pulse s_rst -> out_valid=0 next cycle, no late captures appear, credits=0 and in_ready=1.
